// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates instruction fetch and data access onto a single-port RAM.
// Optional misalignment trap enabled by defining MEM_CTRL_MISALIGN_TRAP_EN.
module mem_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        imem_ren,
  input  logic [31:0] imem_addr,
  output logic        ihit,
  output logic [31:0] imem_load,
  input  logic        dmem_ren,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_store,
  input  logic [1:0]  dmem_width,
  output logic        dhit,
  output logic [31:0] dmem_load,
  output logic        mem_err,
  output logic        ram_ren,
  output logic        ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_be,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ready
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_t;

  localparam logic [9:0] TIMEOUT_CNT = 10'(TIMEOUT);

  state_t      state;
  logic [9:0]  busy_cnt;
  logic [1:0]  req_off;
  logic [1:0]  req_width;
  logic        req_write;

  logic        d_req;
  logic        misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] shifted_b;
  logic [31:0] shifted_h;
  logic [31:0] load_value;

  assign d_req = dmem_ren | dmem_wen;

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
  assign misaligned = ((dmem_width == 2'b01) && dmem_addr[0]) ||
                      (dmem_width[1] && (dmem_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = dmem_store;
    case (dmem_width)
      2'b00: begin
        be_calc    = 4'b0001 << dmem_addr[1:0];
        wdata_calc = {4{dmem_store[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {dmem_addr[1], 1'b0};
        wdata_calc = {2{dmem_store[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = dmem_store;
      end
    endcase
  end

  // Load alignment uses the offset/width latched at request time, not the live inputs.
  assign shifted_b = ram_rdata >> {req_off, 3'b000};
  assign shifted_h = ram_rdata >> {req_off[1], 4'b0000};

  always_comb begin
    load_value = ram_rdata;
    case (req_width)
      2'b00:   load_value = {24'h0, shifted_b[7:0]};
      2'b01:   load_value = {16'h0, shifted_h[15:0]};
      default: load_value = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_cnt  <= 10'd0;
      req_off   <= 2'b00;
      req_width <= 2'b00;
      req_write <= 1'b0;
      ihit      <= 1'b0;
      dhit      <= 1'b0;
      mem_err   <= 1'b0;
      imem_load <= 32'h0;
      dmem_load <= 32'h0;
      ram_ren   <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= 32'h0;
      ram_wdata <= 32'h0;
      ram_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (d_req) begin
            ram_addr  <= dmem_addr & ~32'h3;
            ram_be    <= be_calc;
            ram_wdata <= wdata_calc;
            req_off   <= dmem_addr[1:0];
            req_width <= dmem_width;
            req_write <= dmem_wen;
            if (misaligned) begin
              state     <= RESP;
              dhit      <= 1'b1;
              mem_err   <= 1'b1;
              dmem_load <= 32'h0;
            end else begin
              state    <= D_BUSY;
              ram_wen  <= dmem_wen;
              ram_ren  <= ~dmem_wen;
              busy_cnt <= 10'd1;
            end
          end else if (imem_ren) begin
            ram_addr <= imem_addr & ~32'h3;
            ram_be   <= 4'b1111;
            ram_ren  <= 1'b1;
            busy_cnt <= 10'd1;
            state    <= I_BUSY;
          end
        end

        I_BUSY, D_BUSY: begin
          if (ram_ready) begin
            state   <= RESP;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            mem_err <= 1'b0;
            if (state == I_BUSY) begin
              ihit      <= 1'b1;
              imem_load <= ram_rdata;
            end else begin
              dhit <= 1'b1;
              if (!req_write) begin
                dmem_load <= load_value;
              end
            end
          end else if (busy_cnt == TIMEOUT_CNT) begin
            // Abort: the RAM never answered, so report an error with a zero load value.
            state   <= RESP;
            ram_ren <= 1'b0;
            ram_wen <= 1'b0;
            mem_err <= 1'b1;
            if (state == I_BUSY) begin
              ihit      <= 1'b1;
              imem_load <= 32'h0;
            end else begin
              dhit      <= 1'b1;
              dmem_load <= 32'h0;
            end
          end else begin
            busy_cnt <= busy_cnt + 10'd1;
          end
        end

        RESP: begin
          ihit     <= 1'b0;
          dhit     <= 1'b0;
          mem_err  <= 1'b0;
          busy_cnt <= 10'd0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed cases plus randomized transactions
// checked against a behavioural model of the access rules.
module tb_mem_ctrl;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_ren;
  logic [31:0] imem_addr;
  logic        ihit;
  logic [31:0] imem_load;
  logic        dmem_ren;
  logic        dmem_wen;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_store;
  logic [1:0]  dmem_width;
  logic        dhit;
  logic [31:0] dmem_load;
  logic        mem_err;
  logic        ram_ren;
  logic        ram_wen;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_imem_load = 32'h0;
  logic [31:0] exp_dmem_load = 32'h0;

  mem_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_ren(imem_ren), .imem_addr(imem_addr), .ihit(ihit), .imem_load(imem_load),
    .dmem_ren(dmem_ren), .dmem_wen(dmem_wen), .dmem_addr(dmem_addr),
    .dmem_store(dmem_store), .dmem_width(dmem_width), .dhit(dhit), .dmem_load(dmem_load),
    .mem_err(mem_err), .ram_ren(ram_ren), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_rdata(ram_rdata), .ram_ready(ram_ready)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ihit"}, ihit, 0);
    checkOutput({tag, "_dhit"}, dhit, 0);
    checkOutput({tag, "_mem_err"}, mem_err, 0);
    checkOutput({tag, "_ram_ren"}, ram_ren, 0);
    checkOutput({tag, "_ram_wen"}, ram_wen, 0);
    checkOutput({tag, "_ram_addr"}, ram_addr, 0);
    checkOutput({tag, "_ram_wdata"}, ram_wdata, 0);
    checkOutput({tag, "_ram_be"}, ram_be, 0);
    checkOutput({tag, "_imem_load"}, imem_load, 0);
    checkOutput({tag, "_dmem_load"}, dmem_load, 0);
  endtask

  function automatic logic is_trap(input int kind, input logic [31:0] addr, input logic [1:0] width);
`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    int off = int'(addr[1:0]);
    if (kind == 0) return 1'b0;
    if (width == 2'b01) return (off % 2) != 0;
    if (width >= 2'b10) return off != 0;
    return 1'b0;
`else
    return (kind < 0) && (addr == 32'h0) && (width == 2'b00);
`endif
  endfunction

  // kind: 0 fetch, 1 data read, 2 data write. Caller is at a negedge in IDLE.
  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] store,
                               input logic [1:0] width, input int wait_n,
                               input logic [31:0] rdata, input logic drop_early);
    int          off = int'(addr % 4);
    logic        trap = is_trap(kind, addr, width);
    logic        timed_out = 1'b0;
    logic [31:0] exp_addr = (addr / 4) * 4;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_load;
    if (kind == 0 || width >= 2) begin
      exp_be = 4'hF;
      exp_wdata = store;
      exp_load = rdata;
    end else if (width == 0) begin
      exp_be = 4'(1 << off);
      exp_wdata = {24'h0, store[7:0]} * 32'h01010101;
      exp_load = (rdata >> (8 * off)) & 32'hFF;
    end else begin
      exp_be = 4'(3 << (off & 2));
      exp_wdata = {16'h0, store[15:0]} * 32'h00010001;
      exp_load = (rdata >> (8 * (off & 2))) & 32'hFFFF;
    end

    if (kind == 0) begin
      imem_ren = 1'b1;
      imem_addr = addr;
    end else begin
      dmem_addr = addr;
      dmem_store = store;
      dmem_width = width;
      dmem_wen = (kind == 2);
      dmem_ren = (kind == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    end
    @(posedge clk); @(negedge clk);

    if (!trap) begin
      timed_out = 1'b1;
      for (int c = 1; c <= TIMEOUT; c++) begin
        checkOutput("busy_ram_ren", ram_ren, kind != 2);
        checkOutput("busy_ram_wen", ram_wen, kind == 2);
        checkOutput("busy_ram_addr", ram_addr, exp_addr);
        checkOutput("busy_ram_be", ram_be, exp_be);
        if (kind == 2) checkOutput("busy_ram_wdata", ram_wdata, exp_wdata);
        checkOutput("busy_no_hit", ihit | dhit, 0);
        if (c == wait_n + 1) begin
          ram_ready = 1'b1;
          ram_rdata = rdata;
          timed_out = 1'b0;
        end
        if (drop_early) begin
          imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
        end
        @(posedge clk); @(negedge clk);
        if (!timed_out) break;
      end
      ram_ready = 1'b1;
      ram_rdata = $urandom;
    end

    if (trap || timed_out) exp_load = 32'h0;
    if (kind == 0) exp_imem_load = exp_load;
    else if (kind == 1 || trap || timed_out) exp_dmem_load = exp_load;

    checkOutput("resp_ihit", ihit, kind == 0);
    checkOutput("resp_dhit", dhit, kind != 0);
    checkOutput("resp_mem_err", mem_err, trap | timed_out);
    checkOutput("resp_imem_load", imem_load, exp_imem_load);
    checkOutput("resp_dmem_load", dmem_load, exp_dmem_load);
    checkOutput("resp_ram_req", ram_ren | ram_wen, 0);
    @(posedge clk); @(negedge clk);

    checkOutput("idle_hits", {ihit, dhit, mem_err}, 0);
    checkOutput("idle_no_resample", ram_ren | ram_wen, 0);
    checkOutput("idle_imem_load", imem_load, exp_imem_load);
    checkOutput("idle_dmem_load", dmem_load, exp_dmem_load);
    imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
    ram_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    imem_ren = 1'b0; imem_addr = 32'h0;
    dmem_ren = 1'b0; dmem_wen = 1'b0; dmem_addr = 32'h0;
    dmem_store = 32'h0; dmem_width = 2'b00;
    ram_rdata = 32'h0; ram_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] directed fetch");
    applyStimulus(0, 32'h100, 32'h0, 2'b10, 0, 32'h00A00093, 1'b0);
    checkOutput("fetch_word", imem_load, 32'h00A00093);

    $display("[TB] arbitration");
    imem_ren = 1'b1; imem_addr = 32'h400;
    dmem_ren = 1'b1; dmem_addr = 32'h204; dmem_width = 2'b10;
    @(posedge clk); @(negedge clk);
    checkOutput("arb_d_first_addr", ram_addr, 32'h204);
    checkOutput("arb_d_first_ren", ram_ren, 1);
    ram_ready = 1'b1; ram_rdata = 32'h12345678;
    @(posedge clk); @(negedge clk);
    ram_ready = 1'b0; dmem_ren = 1'b0;
    checkOutput("arb_dhit", {ihit, dhit}, 2'b01);
    checkOutput("arb_dload", dmem_load, 32'h12345678);
    @(posedge clk); @(negedge clk);
    checkOutput("arb_idle", ram_ren, 0);
    @(posedge clk); @(negedge clk);
    checkOutput("arb_i_addr", ram_addr, 32'h400);
    checkOutput("arb_i_ren", ram_ren, 1);
    ram_ready = 1'b1; ram_rdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    ram_ready = 1'b0; imem_ren = 1'b0;
    checkOutput("arb_ihit", {ihit, dhit}, 2'b10);
    checkOutput("arb_iload", imem_load, 32'hCAFEF00D);
    exp_imem_load = 32'hCAFEF00D;
    exp_dmem_load = 32'h12345678;
    @(posedge clk); @(negedge clk);

    $display("[TB] byte store/load");
    applyStimulus(2, 32'h303, 32'h000000AB, 2'b00, 0, 32'h0, 1'b0);
    applyStimulus(1, 32'h303, 32'h0, 2'b00, 1, 32'h7F000000, 1'b0);
    checkOutput("byte_load", dmem_load, 32'h0000007F);

    $display("[TB] timeout boundaries");
    applyStimulus(1, 32'h40, 32'h0, 2'b10, 100, 32'hDEADBEEF, 1'b0);
    checkOutput("timeout_load", dmem_load, 32'h0);
    applyStimulus(1, 32'h44, 32'h0, 2'b10, TIMEOUT - 1, 32'h55AA55AA, 1'b0);
    checkOutput("last_cycle_load", dmem_load, 32'h55AA55AA);
    applyStimulus(1, 32'h48, 32'h0, 2'b01, 2, 32'hBEEF1234, 1'b1);

`ifdef MEM_CTRL_MISALIGN_TRAP_EN
    $display("[TB] misaligned trap");
    applyStimulus(1, 32'h102, 32'h0, 2'b10, 0, 32'h11111111, 1'b0);
`endif

    $display("[TB] random transactions");
    for (int n = 0; n < 40; n++) begin
      applyStimulus(int'($urandom_range(0, 2)), $urandom, $urandom, 2'($urandom_range(0, 3)),
                    int'($urandom_range(0, 5)), $urandom, $urandom_range(0, 3) == 0);
    end

    $display("[TB] reset during busy");
    dmem_ren = 1'b1; dmem_addr = 32'h80; dmem_width = 2'b10;
    @(posedge clk); @(negedge clk);
    checkOutput("rst_busy_ren", ram_ren, 1);
    #2 rst = 1'b1;
    #1 checkAllZero("async_rst");
    dmem_ren = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    exp_imem_load = 32'h0;
    exp_dmem_load = 32'h0;
    for (int c = 0; c < 6; c++) begin
      if (c == 1) ram_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      checkOutput("post_rst_quiet", {dhit, ihit, ram_ren, ram_wen}, 0);
    end
    ram_ready = 1'b0;
    applyStimulus(0, 32'h10, 32'h0, 2'b10, 0, 32'h0000ABCD, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
